// File: rtl/cn_msg_expander_20_if.sv
// Handshake bundle for the check-node message expander: compressed row in, per-edge message out.
interface cn_msg_expander_20_if #(
  parameter int unsigned NOB = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [NOB:0]   in_min1;
  logic [NOB:0]   in_min2;
  logic [4:0]     in_min1_index;
  logic [19:0]    in_signs;
  logic [4:0]     in_deg;

  logic           out_valid;
  logic           out_ready;
  logic           out_sign;
  logic [NOB:0]   out_mag;
  logic [4:0]     out_edge;
  logic           out_last;

  modport master (
    output in_valid, in_min1, in_min2, in_min1_index, in_signs, in_deg, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_edge, out_last
  );

  modport slave (
    input  in_valid, in_min1, in_min2, in_min1_index, in_signs, in_deg, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_edge, out_last
  );
endinterface

// File: rtl/cn_msg_expander_20.sv
// Expands a compressed min-sum check-node row into one offset-corrected message per edge,
// serially, with a two-entry row buffer so the next row can be accepted during emission.
module cn_msg_expander_20 #(
  parameter int unsigned NOB    = 4,
  parameter int unsigned OFFSET = 1
) (
  input logic                clk,
  input logic                rst_n,
  cn_msg_expander_20_if.slave bus
);
  localparam int unsigned MagW = NOB + 1;

  typedef struct packed {
    logic [MagW-1:0] min1;
    logic [MagW-1:0] min2;
    logic [4:0]      idx;
    logic [19:0]     signs;
    logic [4:0]      deg;
    logic            tsign;
  } entry_t;

  typedef enum logic {StIdle, StEmit} state_e;

  entry_t          mem_q [2];
  entry_t          mem_d [2];
  entry_t          in_entry;
  entry_t          head;
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic [4:0]      e_q, e_d;
  state_e          state_q, state_d;
  logic            push, fire, pop;
  logic [MagW-1:0] sel;

  logic            out_valid_q, out_valid_d;
  logic            out_sign_q, out_sign_d;
  logic            out_last_q, out_last_d;
  logic [MagW-1:0] out_mag_q, out_mag_d;
  logic [4:0]      out_edge_q, out_edge_d;

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_edge  = out_edge_q;
  assign bus.out_last  = out_last_q;

  assign push = bus.in_valid & bus.in_ready;
  assign fire = out_valid_q & bus.out_ready;
  assign pop  = fire & out_last_q;

  // Degree is clamped and the row parity precomputed once, at capture.
  always_comb begin
    in_entry       = '0;
    in_entry.min1  = bus.in_min1;
    in_entry.min2  = bus.in_min2;
    in_entry.idx   = bus.in_min1_index;
    in_entry.signs = bus.in_signs;
    in_entry.deg   = (bus.in_deg == 5'd0 || bus.in_deg > 5'd20) ? 5'd20 : bus.in_deg;
    in_entry.tsign = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (5'(i) < in_entry.deg) in_entry.tsign = in_entry.tsign ^ bus.in_signs[i];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    e_d      = e_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      e_d      = '0;
    end else if (fire) begin
      e_d = e_q + 5'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (push) state_d = StEmit;
      StEmit:  if (pop && count_d == 2'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are precomputed from next-state so they leave the flops already aligned.
  always_comb begin
    head        = mem_d[rd_ptr_d];
    sel         = (e_d == head.idx) ? head.min2 : head.min1;
    out_valid_d = 1'b0;
    out_sign_d  = 1'b0;
    out_mag_d   = '0;
    out_edge_d  = '0;
    out_last_d  = 1'b0;
    if (state_d == StEmit) begin
      out_valid_d = 1'b1;
      out_mag_d   = (sel > MagW'(OFFSET)) ? sel - MagW'(OFFSET) : '0;
      out_sign_d  = head.tsign ^ head.signs[e_d];
      out_edge_d  = e_d;
      out_last_d  = (e_d == head.deg - 5'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      e_q         <= 5'd0;
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_mag_q   <= '0;
      out_edge_q  <= 5'd0;
      out_last_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      e_q         <= e_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_mag_q   <= out_mag_d;
      out_edge_q  <= out_edge_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_cn_msg_expander_20.sv
// Directed, table-driven bench for cn_msg_expander_20 (NOB=4, OFFSET=1).
module tb_cn_msg_expander_20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cn_msg_expander_20_if #(.NOB(4)) bus ();

  cn_msg_expander_20 #(.NOB(4), .OFFSET(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  min1;
    logic [4:0]  min2;
    logic [4:0]  idx;
    logic [19:0] signs;
    logic [4:0]  deg;
    int          n;      // expected message count
    logic [4:0]  mag1;   // expected magnitude on min1 edges
    logic [4:0]  mag2;   // expected magnitude on the min1_index edge
    logic        tsign;  // expected parity of active sign bits
  } vec_t;

  vec_t vt[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {valid, edge, mag, sign, last}
  function automatic logic [12:0] model(input vec_t v, input int e);
    logic [4:0] mag;
    mag = (e == int'(v.idx)) ? v.mag2 : v.mag1;
    return {1'b1, 5'(e), mag, v.tsign ^ v.signs[e], (e == v.n - 1)};
  endfunction

  function automatic logic [12:0] actual();
    return {bus.out_valid, bus.out_edge, bus.out_mag, bus.out_sign, bus.out_last};
  endfunction

  task automatic drive(input vec_t v);
    bus.in_min1       = v.min1;
    bus.in_min2       = v.min2;
    bus.in_min1_index = v.idx;
    bus.in_signs      = v.signs;
    bus.in_deg        = v.deg;
  endtask

  task automatic run_row(input vec_t v, input int id);
    drive(v);
    bus.in_valid = 1'b1;
    check($sformatf("row%0d ready", id), 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int e = 0; e < v.n; e++) begin
      check($sformatf("row%0d edge%0d", id, e), 32'(actual()), 32'(model(v, e)));
      tick();
    end
    check($sformatf("row%0d idle", id), 32'(actual()), 32'd0);
  endtask

  initial begin
    vec_t a, b;
    logic [12:0] snap;
    logic stalled;
    int exp_e, cyc;

    vt[0] = '{5'd3, 5'd7, 5'd5, 20'h00001, 5'd20, 20, 5'd2, 5'd6, 1'b1};
    vt[1] = '{5'd1, 5'd0, 5'd25, 20'h0000A, 5'd4, 4, 5'd0, 5'd0, 1'b0};
    vt[2] = '{5'd5, 5'd9, 5'd19, 20'h80000, 5'd0, 20, 5'd4, 5'd8, 1'b1};
    vt[3] = '{5'd4, 5'd6, 5'd0, 20'hFFFFE, 5'd1, 1, 5'd3, 5'd5, 1'b0};
    vt[4] = '{5'd0, 5'd2, 5'd10, 20'hF0F0F, 5'd25, 20, 5'd0, 5'd1, 1'b0};
    vt[5] = '{5'd6, 5'd6, 5'd2, 20'h00015, 5'd5, 5, 5'd5, 5'd5, 1'b1};
    vt[6] = '{5'd31, 5'd31, 5'd0, 20'h00000, 5'd31, 20, 5'd30, 5'd30, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(vt[0]);
    #12;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset outputs", 32'(actual()), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_row(vt[i], i);

    // Two rows buffered behind a stalled output, third push refused.
    a = '{5'd2, 5'd4, 5'd1, 20'h00000, 5'd3, 3, 5'd1, 5'd3, 1'b0};
    b = '{5'd5, 5'd8, 5'd0, 20'h00007, 5'd3, 3, 5'd4, 5'd7, 1'b1};
    bus.out_ready = 1'b0;
    drive(a);
    bus.in_valid = 1'b1;
    tick();
    drive(b);
    tick();
    drive(vt[5]);
    check("full in_ready", 32'(bus.in_ready), 32'd0);
    check("full head", 32'(actual()), 32'(model(a, 0)));
    tick();
    check("full in_ready held", 32'(bus.in_ready), 32'd0);
    check("full head held", 32'(actual()), 32'(model(a, 0)));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("b2b msg%0d", k), 32'(actual()), 32'(model(k < 3 ? a : b, k % 3)));
      if (k == 2) check("b2b ready before pop", 32'(bus.in_ready), 32'd0);
      if (k == 3) check("b2b ready after pop", 32'(bus.in_ready), 32'd1);
      tick();
    end
    check("b2b idle (third row dropped)", 32'(actual()), 32'd0);

    // Random stalls on a full-degree row.
    drive(vt[0]);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    exp_e   = 0;
    stalled = 1'b0;
    snap    = '0;
    cyc     = 0;
    while (exp_e < 20 && cyc < 400) begin
      if (stalled) check($sformatf("stall hold e%0d", exp_e), 32'(actual()), 32'(snap));
      snap          = actual();
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          check($sformatf("stall msg%0d", exp_e), 32'(actual()), 32'(model(vt[0], exp_e)));
          exp_e++;
        end
      end
      stalled = bus.out_valid & ~bus.out_ready;
      tick();
      cyc++;
    end
    check("stall edges delivered", 32'(exp_e), 32'd20);
    bus.out_ready = 1'b1;
    check("stall idle", 32'(actual()), 32'd0);

    // Asynchronous reset in the middle of a row.
    drive(vt[0]);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_edge != 5'd7 && cyc < 30) begin
      tick();
      cyc++;
    end
    check("mid-row reached edge7", 32'(bus.out_edge), 32'd7);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(bus.out_valid), 32'd0);
    check("async reset in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post reset quiet 1", 32'(actual()), 32'd0);
    tick();
    check("post reset quiet 2", 32'(actual()), 32'd0);
    run_row(vt[3], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cn_msg_expander_20.md
# cn_msg_expander_20

Check-node message expander for the 20-input min-sum check node. Accepts one compressed check-node result per row: min1, min2, min1 index, per-edge sign vector and active row degree. Expands it into one check-to-variable message per edge, serially, one per clock, applying offset min-sum correction. Sits between the min-sum tree and the variable-node update path, and holds a two-entry buffer so a new row can be accepted while the previous row is still being emitted.

## Interface
- NOB, 4: magnitude MSB index; magnitudes are NOB+1 bits wide.
- OFFSET, 1: offset subtracted from the selected magnitude, saturating at 0.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  compressed row presented
- in_ready  output  1  expander can accept a row this cycle
- in_min1  input  NOB+1  smallest magnitude
- in_min2  input  NOB+1  second-smallest magnitude
- in_min1_index  input  5  edge holding min1 (0..19)
- in_signs  input  20  per-edge input sign, bit i = edge i (1 = negative)
- in_deg  input  5  active edges in the row (1..20)
- out_valid  output  1  message valid
- out_ready  input  1  downstream accepts message
- out_sign  output  1  message sign
- out_mag  output  NOB+1  message magnitude
- out_edge  output  5  edge index of message
- out_last  output  1  final edge of the row

## Operation
- Buffer: two-entry FIFO of {min1, min2, min1_index, signs, deg}. Handshake on in_valid & in_ready. in_ready = (occupancy < 2), derived from registered state only.
- Capture-time normalisation:
  - in_deg of 0 or >20 is stored as 20.
  - total_sign is computed as the XOR of in_signs bits 0..deg-1; bits at or above deg are ignored.
- States:
  - IDLE: buffer empty, out_valid=0.
  - EMIT: head entry being expanded, edge counter e runs 0..deg-1.
- Transitions:
  - IDLE→EMIT: on the cycle an entry is written while the buffer is empty.
  - In EMIT, when out_valid & out_ready & out_last: pop the head and reset e to 0. Stay in EMIT if another entry remains; otherwise go to IDLE.
- Per-message output at edge e:
  - sel = (e == min1_index) ? min2 : min1
  - out_mag = (sel > OFFSET) ? sel − OFFSET : 0, computed at NOB+1 bits with no wrap.
  - out_sign = total_sign ^ signs[e]
  - out_edge = e
  - out_last = (e == deg−1)
- Edge cases:
  - min1_index ≥ deg: every edge receives min1.
  - min1 == min2: the output is still well defined; no special case is needed.
- Stall: while out_valid & !out_ready, all out_* are held stable and e does not advance.
- Simultaneous push and pop on a full buffer: in_ready is 0, so no push can occur. Push and pop on a one-entry buffer are both performed and occupancy stays 1.
- Reset, including in the middle of a row: buffer is emptied, e=0, state=IDLE, and any partially emitted row is discarded. No message from it appears after reset.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sign=0, out_mag=0, out_edge=0, out_last=0.
- All outputs are registered.
- Latency: a row accepted in cycle t into an empty expander gives out_valid=1 with edge 0 in cycle t+1.
- Throughput: one message per cycle when out_ready=1. A row of degree d occupies d cycles.
- Back-to-back rows: the cycle after the last edge of row A is accepted presents edge 0 of row B, with no bubble, if B is buffered.
- in_ready falls the cycle after the second entry is captured. It rises the cycle after the row-final pop.

## Test plan
- Reset then single row: min1=3, min2=7, idx=5, signs=20'h00001, deg=20, OFFSET=1, out_ready=1. Expect 20 messages in consecutive cycles starting 1 cycle after accept:
  - edge 5: mag 6
  - all other edges: mag 2
  - total_sign=1, so edge 0 has sign 0 and all others sign 1
  - out_last only on edge 19
- Saturation and index out of range: min1=1, min2=0, idx=25, deg=4, OFFSET=1. Expect 4 messages, all with mag 0 (never wrapped to 31), out_last on edge 3.
- Back-to-back and full buffer: push three rows of deg=3 with out_ready held 0.
  - The third push is blocked (in_ready=0 after two captures).
  - Release out_ready: 6 messages with no bubble between rows. in_ready returns 1 one cycle after edge 2 of row 1.
- Random out_ready stalls on a deg=20 row: outputs stay stable during every stall, and the edge sequence is 0..19 exactly once.
- Degree handling:
  - deg=0 is treated as 20 messages.
  - deg=1 gives a single message with out_last=1, and the sign ignores signs bits 1..19.
- Reset asserted at edge 7 of a row: out_valid=0 and in_ready=1 immediately (asynchronous). After release, the next row starts at edge 0, and no stale messages appear.
